// File: rtl/bp_be_fe_queue_pkg.sv
// Shared types and helpers for the FE->BE queue: control decode bundle and pointer sizing.
package bp_be_fe_queue_pkg;

    localparam int unsigned fe_queue_width_lp = 128;

    // Per-cycle operations after clr > roll > {yumi, deq, enq} priority has been applied
    typedef struct packed {
        logic clr;
        logic roll;
        logic enq;
        logic yumi;
        logic deq;
    } fe_queue_ctrl_s;

    function automatic int unsigned fe_queue_ptr_width(input int unsigned els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// Wrap-bit pointer: increments by one with natural wrap, or loads a new value (load wins).
module bp_be_fe_queue_ptr #(
    parameter int unsigned ptr_width_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   inc_i,
    input  logic                   load_i,
    input  logic [ptr_width_p-1:0] load_val_i,
    output logic [ptr_width_p-1:0] ptr_o
);

    logic [ptr_width_p-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + ptr_width_p'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_be_fe_queue.sv
// Checkpointed FE->BE queue with speculative read, commit (deq), roll-back and clear.
// Optional same-cycle bypass of an enqueue into an empty queue: define BP_BE_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue
    import bp_be_fe_queue_pkg::*;
#(
    parameter int unsigned els_p   = 8,
    parameter int unsigned width_p = fe_queue_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_n_i,

    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,

    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,

    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i
);

    localparam int unsigned ptr_width_lp = fe_queue_ptr_width(els_p);
    localparam int unsigned idx_width_lp = ptr_width_lp - 1;
    localparam logic [ptr_width_lp-1:0] full_diff_lp = ptr_width_lp'(els_p);

    logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_next, rptr_load_val;
    logic [width_p-1:0]      mem_q [els_p];
    logic                    ready_en_q;
    logic                    empty;
    fe_queue_ctrl_s          ctrl;

    always_comb begin
        ctrl      = '0;
        ctrl.clr  = fe_queue_clr_i;
        ctrl.roll = fe_queue_roll_i & ~fe_queue_clr_i;
        ctrl.enq  = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
        ctrl.yumi = fe_queue_yumi_i & ~fe_queue_clr_i & ~fe_queue_roll_i;
        ctrl.deq  = fe_queue_deq_i & ~fe_queue_clr_i;
    end

    // A roll that coincides with a deq rewinds to the freshly committed checkpoint
    assign cptr_next     = ctrl.deq ? cptr + ptr_width_lp'(1) : cptr;
    assign rptr_load_val = ctrl.clr ? wptr : cptr_next;

    bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_wptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (ctrl.enq),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (wptr)
    );

    bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_rptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (ctrl.yumi),
        .load_i     (ctrl.clr | ctrl.roll),
        .load_val_i (rptr_load_val),
        .ptr_o      (rptr)
    );

    bp_be_fe_queue_ptr #(.ptr_width_p(ptr_width_lp)) u_cptr (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .inc_i      (ctrl.deq),
        .load_i     (ctrl.clr),
        .load_val_i (wptr),
        .ptr_o      (cptr)
    );

    // Holds ready low during reset; pointers alone would already look non-full
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ctrl.enq) begin
            mem_q[wptr[idx_width_lp-1:0]] <= fe_queue_i;
        end
    end

    assign fe_queue_ready_o = ready_en_q & ((wptr - cptr) != full_diff_lp);
    assign empty            = (rptr == wptr);

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass       = empty & ctrl.enq;
    assign fe_queue_v_o = ~empty | bypass;
    assign fe_queue_o   = bypass ? fe_queue_i : mem_q[rptr[idx_width_lp-1:0]];
`else
    assign fe_queue_v_o = ~empty;
    assign fe_queue_o   = mem_q[rptr[idx_width_lp-1:0]];
`endif

endmodule
